masku_cmp_sequencer: RTL
========================

MASKU_CMP_SEQUENCER -- requirements
Module: masku_cmp_sequencer

Interface
REQ-001 SHALL have parameter NrLanes, default 0 (must be overridden with a power of two, 1..16), meaning number of lanes feeding the mask unit.
REQ-002 SHALL derive localparam DATAPATH_WIDTH = NrLanes*ELEN, meaning bits per mask result word.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port vinsn_valid_i  input  1  new compare instruction offered.
REQ-006 SHALL have port vinsn_ready_o  output  1  instruction accepted when high with vinsn_valid_i.
REQ-007 SHALL have port vl_i  input  vlen_t  element count, sampled on instruction accept.
REQ-008 SHALL have port vsew_i  input  vew_e  source SEW, sampled on instruction accept.
REQ-009 SHALL have port operand_valid_i  input  NrLanes  per-lane ALU/FPU result valid.
REQ-010 SHALL have port operand_ready_o  output  NrLanes  per-lane operand pop.
REQ-011 SHALL have port compress_en_o  output  1  high in the cycle a beat fires; compressor writes this beat.
REQ-012 SHALL have port vrf_pnt_o  output  idx_width(DATAPATH_WIDTH)+1  bit offset in the result word for the current beat.
REQ-013 SHALL have port result_valid_o  output  1  compressed result word complete.
REQ-014 SHALL have port result_ready_i  input  1  downstream VRF write accepts the word.
REQ-015 SHALL have port result_last_o  output  1  qualifies result_valid_o as the instruction's final word.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse on instruction completion.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; vinsn_ready_o = 1 only in IDLE.
REQ-018 On accept with vl_i>0: remaining <= vl_i, sew <= vsew_i, vrf_pnt <= 0, next state RUN; with vl_i==0: stay IDLE, pulse done_o the next cycle, emit no result.
REQ-019 elems_per_beat SHALL be NrLanes*(8>>sew); a beat consumes min(remaining, elems_per_beat) elements.
REQ-020 A beat SHALL fire iff state==RUN, &operand_valid_i, and (!result_valid_o || result_ready_i); in that cycle operand_ready_o='1 and compress_en_o=1, else operand_ready_o='0 (no per-lane partial pops).
REQ-021 vrf_pnt_o SHALL show the pre-beat offset during a firing beat; after the beat vrf_pnt += consumed, wrapping to 0 exactly at DATAPATH_WIDTH.
REQ-022 result_valid_o SHALL rise the cycle after a beat that reaches DATAPATH_WIDTH or drives remaining to 0, and hold until result_ready_i.
REQ-023 result_last_o SHALL be 1 with result_valid_o iff remaining==0.
REQ-024 A beat driving remaining to 0 SHALL move RUN->DRAIN; DRAIN->IDLE on result handshake, with done_o=1 in that handshake cycle.
REQ-025 A result handshake and a new filling beat in the same cycle SHALL keep result_valid_o high for the new word without a bubble.
REQ-026 Beat count per instruction SHALL equal ceil(vl/elems_per_beat); vl>DATAPATH_WIDTH SHALL produce multiple words.

Reset
REQ-027 On rst_i (any state, mid-instruction included): state IDLE, remaining 0, vrf_pnt 0, all outputs 0 except vinsn_ready_o which SHALL be 1 after release.
REQ-028 Reset SHALL not produce a done_o pulse or a result handshake.

Structure
REQ-029 State enum and ELEN, vlen_t, vew_e SHALL come from ara_pkg; only the state enum is local-to-ara_pkg addition.
REQ-030 No sub-module; compressor datapath stays outside, driven by compress_en_o and vrf_pnt_o.

Verification (NrLanes=4, DATAPATH_WIDTH=256)
REQ-031 vl=64, EW8, lanes always valid -> 2 beats, vrf_pnt 0,32; one word with last=1; done_o on its handshake.
REQ-032 vl=512, EW8 -> 16 beats; word after beat 8 (last=0, pnt wraps to 0), word after beat 16 (last=1).
REQ-033 vl=6, EW64 -> 2 beats consuming 4 then 2; vrf_pnt 0,4; one last word.
REQ-034 vl=256, EW8, result_ready_i low 3 cycles after word 1 -> operand_ready_o stays 0, vrf_pnt held; resumes on ack.
REQ-035 rst_i asserted at beat 5 of vl=512 -> next cycle IDLE, all outputs 0, no done_o; new instruction runs cleanly.
REQ-036 vl=0 -> accepted, no beat, no result, done_o one cycle later.

Source files
------------

// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared vector types, element widths and mask-compare sequencer states
package ara_pkg;

   localparam int unsigned ELEN = 64;

   typedef logic [15:0] vlen_t;

   typedef enum logic [1:0] {
      EW8  = 2'd0,
      EW16 = 2'd1,
      EW32 = 2'd2,
      EW64 = 2'd3
   } vew_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } cmp_state_e;

   function automatic int unsigned idx_width(input int unsigned num);
      return (num > 1) ? unsigned'($clog2(num)) : 1;
   endfunction

endpackage

// File: rtl/masku_cmp_sequencer.sv
// rtl/masku_cmp_sequencer.sv - beat sequencer packing per-lane compare results into mask words
module masku_cmp_sequencer
   import ara_pkg::*;
#(
   parameter int unsigned NrLanes = 0,
   localparam int unsigned DATAPATH_WIDTH = NrLanes * ELEN,
   localparam int unsigned LaneW = (NrLanes > 0) ? NrLanes : 1,
   localparam int unsigned PntW = idx_width(DATAPATH_WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             vinsn_valid_i,
   output logic             vinsn_ready_o,
   input  vlen_t            vl_i,
   input  vew_e             vsew_i,
   input  logic [LaneW-1:0] operand_valid_i,
   output logic [LaneW-1:0] operand_ready_o,
   output logic             compress_en_o,
   output logic [PntW-1:0]  vrf_pnt_o,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic             result_last_o,
   output logic             done_o
);

   cmp_state_e      state;
   vlen_t           remaining;
   vew_e            sew;
   logic [PntW-1:0] vrf_pnt;
   logic            result_valid;
   logic            result_last;
   logic            done_q;

   logic [PntW-1:0] epb;
   logic [PntW-1:0] consumed;
   logic [PntW-1:0] pnt_sum;
   vlen_t           rem_after;
   logic            word_full;
   logic            fire;
   logic            res_hs;

   // One mask bit per element, so a beat advances the pointer by its element count
   always_comb begin
      epb       = PntW'(NrLanes) << (2'd3 - 2'(sew));
      consumed  = (remaining < vlen_t'(epb)) ? PntW'(remaining) : epb;
      pnt_sum   = vrf_pnt + consumed;
      rem_after = remaining - vlen_t'(consumed);
      word_full = (pnt_sum == PntW'(DATAPATH_WIDTH));
      res_hs    = result_valid && result_ready_i;
      fire      = (state == RUN) && (&operand_valid_i) && (!result_valid || result_ready_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         remaining    <= '0;
         sew          <= EW8;
         vrf_pnt      <= '0;
         result_valid <= 1'b0;
         result_last  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (res_hs) begin
            result_valid <= 1'b0;
            result_last  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (vinsn_valid_i) begin
                  if (vl_i != '0) begin
                     remaining <= vl_i;
                     sew       <= vsew_i;
                     vrf_pnt   <= '0;
                     state     <= RUN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fire) begin
                  remaining <= rem_after;
                  vrf_pnt   <= word_full ? '0 : pnt_sum;
                  // Setting valid here overrides the handshake clear above: back-to-back words
                  if (word_full || rem_after == '0) begin
                     result_valid <= 1'b1;
                     result_last  <= (rem_after == '0);
                  end
                  if (rem_after == '0) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (res_hs) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign vinsn_ready_o   = (state == IDLE) && !rst_i;
   assign operand_ready_o = fire ? '1 : '0;
   assign compress_en_o   = fire;
   assign vrf_pnt_o       = vrf_pnt;
   assign result_valid_o  = result_valid;
   assign result_last_o   = result_last;
   assign done_o          = done_q || ((state == DRAIN) && res_hs);

endmodule
